// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: immediate
// formats, opcodes, state encoding, datapath select codes and per-state Moore outputs.
package multicycle_control_fsm_pkg;

  localparam logic [2:0] I_TYPE   = 3'd0;
  localparam logic [2:0] S_TYPE   = 3'd1;
  localparam logic [2:0] B_TYPE   = 3'd2;
  localparam logic [2:0] U_TYPE   = 3'd3;
  localparam logic [2:0] J_TYPE   = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LOAD_WB  = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic       ADDR_PC       = 1'b0;
  localparam logic       ADDR_ALUOUT   = 1'b1;
  localparam logic [1:0] SRC_A_PC      = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC   = 2'd1;
  localparam logic [1:0] SRC_A_RS1     = 2'd2;
  localparam logic [1:0] SRC_B_RS2     = 2'd0;
  localparam logic [1:0] SRC_B_IMM     = 2'd1;
  localparam logic [1:0] SRC_B_CONST4  = 2'd2;
  localparam logic [1:0] ALU_ADD       = 2'd0;
  localparam logic [1:0] ALU_BRANCH    = 2'd1;
  localparam logic [1:0] ALU_FUNCT     = 2'd2;
  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;
  localparam logic [1:0] WB_ALUOUT     = 2'd0;
  localparam logic [1:0] WB_MEMDATA    = 2'd1;
  localparam logic [1:0] WB_PC         = 2'd2;
  localparam logic [1:0] WB_IMM        = 2'd3;

  typedef struct packed {
    logic       mem_valid;
    logic       mem_we;
    logic       addr_sel;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
  } ctrl_t;

  // State-only outputs; the FETCH/BRANCH Mealy terms are added in the top.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_valid = 1'b1;
        c.addr_sel  = ADDR_PC;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_CONST4;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB, S_AUIPC: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_ALUOUT;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_valid = 1'b1;
        c.addr_sel  = ADDR_ALUOUT;
      end
      S_LOAD_WB: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_MEMDATA;
      end
      S_MEM_WR: begin
        c.mem_valid = 1'b1;
        c.mem_we    = 1'b1;
        c.addr_sel  = ADDR_ALUOUT;
      end
      S_BRANCH: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_BRANCH;
        c.pc_src    = PC_SRC_ALUOUT;
      end
      S_JAL: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_PC;
        c.pc_write  = 1'b1;
        c.pc_src    = PC_SRC_ALUOUT;
      end
      S_JALR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_SRC_ALU;
        c.pc_write  = 1'b1;
        c.reg_write = 1'b1;
        c.wb_sel    = WB_PC;
      end
      S_LUI: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_IMM;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath/memory (slave).
interface multicycle_control_fsm_if #(parameter int INSTRET_W = 32);
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 mem_ready;
  logic                 mem_valid;
  logic                 mem_we;
  logic                 addr_sel;
  logic                 ir_write;
  logic                 pc_write;
  logic                 pc_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic [2:0]           imm_sel;
  logic                 trap;
  logic [INSTRET_W-1:0] instret;
  logic [3:0]           state;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_valid, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, imm_sel,
           trap, instret, state
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_valid, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, imm_sel,
           trap, instret, state
  );
endinterface

// File: rtl/multicycle_control_fsm_opcode_imm_class.sv
// Combinational opcode to immediate-format classifier feeding imm_extend.
module opcode_imm_class
  import multicycle_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel
);
  always_comb begin
    imm_sel = IMM_NONE;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR: imm_sel = I_TYPE;
      OP_STORE:               imm_sel = S_TYPE;
      OP_BRANCH:              imm_sel = B_TYPE;
      OP_JAL:                 imm_sel = J_TYPE;
      OP_LUI, OP_AUIPC:       imm_sel = U_TYPE;
      default:                imm_sel = IMM_NONE;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer with memory handshake and retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to park illegal opcodes in a sticky TRAP state.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 on mem_ready
// DECODE   | ALUOUT = OLDPC + imm, dispatch on opcode
// EXEC_R/I | ALU op on rs1 with rs2 / imm
// ALU_WB   | rd <= ALUOUT
// MEM_ADDR | ALUOUT = rs1 + imm
// MEM_RD   | load access, wait for mem_ready
// LOAD_WB  | rd <= memory data
// MEM_WR   | store access, wait for mem_ready
// BRANCH   | compare, PC <= ALUOUT if taken
// JAL/JALR | rd <= PC, PC <= target
// LUI      | rd <= imm
// AUIPC    | rd <= ALUOUT
// TRAP     | illegal opcode, held until reset
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  state_t               state_q;
  state_t               state_nxt;
  ctrl_t                ctrl_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;
  logic [2:0]           imm_class;
  logic                 live;

  opcode_imm_class u_imm_class (
    .opcode  (bus.opcode),
    .imm_sel (imm_class)
  );

  always_comb begin
    state_nxt = state_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:           state_nxt = S_TRAP;
`else
          default:           state_nxt = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
      S_MEM_ADDR: state_nxt = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_nxt = S_LOAD_WB;
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_nxt = S_TRAP;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_q;
`endif

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= state_ctrl(S_FETCH);
      instret_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= state_ctrl(state_nxt);
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_q  <= (state_nxt == S_TRAP);
`endif
    end
  end

  // Reset blanks every output in the same cycle, dropping any pending request.
  assign live          = !reset;
  assign bus.mem_valid = live & ctrl_q.mem_valid;
  assign bus.mem_we    = live & ctrl_q.mem_we;
  assign bus.addr_sel  = live & ctrl_q.addr_sel;
  assign bus.ir_write  = live & (state_q == S_FETCH) & bus.mem_ready;
  assign bus.pc_write  = live & (ctrl_q.pc_write
                                 | ((state_q == S_FETCH) & bus.mem_ready)
                                 | ((state_q == S_BRANCH) & bus.branch_taken));
  assign bus.pc_src    = live & ctrl_q.pc_src;
  assign bus.alu_src_a = live ? ctrl_q.alu_src_a : 2'd0;
  assign bus.alu_src_b = live ? ctrl_q.alu_src_b : 2'd0;
  assign bus.alu_op    = live ? ctrl_q.alu_op : 2'd0;
  assign bus.reg_write = live & ctrl_q.reg_write;
  assign bus.wb_sel    = live ? ctrl_q.wb_sel : 2'd0;
  assign bus.imm_sel   = live ? imm_class : 3'd0;
  assign bus.instret   = live ? instret_q : '0;
  assign bus.state     = live ? state_q : 4'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.trap      = live & trap_q;
`else
  assign bus.trap      = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: per-instruction step lists model the sequencer.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  logic clk;
  logic reset;
  multicycle_control_fsm_if #(.INSTRET_W(32)) bus ();

  multicycle_control_fsm #(.INSTRET_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the current instruction is a list of states it must visit.
  state_t      steps[$];
  int          idx;
  logic        illegal;
  logic [31:0] instret_m;
  logic [6:0]  next_op;
  logic        run_chk;

  function automatic state_t cur_state();
    return steps[idx];
  endfunction

  function automatic logic [2:0] imm_model(logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: return 3'd0;
      7'b0100011:                         return 3'd1;
      7'b1100011:                         return 3'd2;
      7'b0110111, 7'b0010111:             return 3'd3;
      7'b1101111:                         return 3'd4;
      default:                            return 3'd7;
    endcase
  endfunction

  // {mem_valid, mem_we, addr_sel, pc_write, pc_src, alu_a, alu_b, alu_op, reg_write, wb_sel, trap}
  function automatic logic [14:0] row(state_t s);
    case (s)
      S_FETCH:    return {5'b10000, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0};
      S_DECODE:   return {5'b00000, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0};
      S_EXEC_R:   return {5'b00000, 2'd2, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0};
      S_EXEC_I:   return {5'b00000, 2'd2, 2'd1, 2'd2, 1'b0, 2'd0, 1'b0};
      S_ALU_WB:   return {5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0};
      S_MEM_ADDR: return {5'b00000, 2'd2, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0};
      S_MEM_RD:   return {5'b10100, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
      S_LOAD_WB:  return {5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0};
      S_MEM_WR:   return {5'b11100, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
      S_BRANCH:   return {5'b00001, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0};
      S_JAL:      return {5'b00011, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0};
      S_JALR:     return {5'b00010, 2'd2, 2'd1, 2'd0, 1'b1, 2'd2, 1'b0};
      S_LUI:      return {5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'd3, 1'b0};
      S_AUIPC:    return {5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0};
      S_TRAP:     return {5'b00000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1};
      default:    return '0;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle just ended.
  task automatic advance();
    state_t c;
    c = cur_state();
    if (reset) begin
      steps = '{S_FETCH};
      idx = 0;
      instret_m = 32'd0;
      illegal = 1'b0;
    end else if ((c == S_FETCH || c == S_MEM_RD || c == S_MEM_WR) && !bus.mem_ready) begin
      idx = idx;
    end else if (c == S_TRAP) begin
      idx = idx;
    end else if (c == S_FETCH) begin
      bus.opcode = next_op;
      illegal = 1'b0;
      steps = '{S_FETCH, S_DECODE};
      case (next_op)
        7'b0110011: begin steps.push_back(S_EXEC_R); steps.push_back(S_ALU_WB); end
        7'b0010011: begin steps.push_back(S_EXEC_I); steps.push_back(S_ALU_WB); end
        7'b0000011: begin steps.push_back(S_MEM_ADDR); steps.push_back(S_MEM_RD);
                          steps.push_back(S_LOAD_WB); end
        7'b0100011: begin steps.push_back(S_MEM_ADDR); steps.push_back(S_MEM_WR); end
        7'b1100011: steps.push_back(S_BRANCH);
        7'b1101111: steps.push_back(S_JAL);
        7'b1100111: steps.push_back(S_JALR);
        7'b0110111: steps.push_back(S_LUI);
        7'b0010111: steps.push_back(S_AUIPC);
        default: begin
          illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          steps.push_back(S_TRAP);
`endif
        end
      endcase
      idx = 1;
    end else if (idx + 1 < steps.size()) begin
      idx++;
    end else begin
      if (!illegal) instret_m = instret_m + 32'd1;
      steps = '{S_FETCH};
      idx = 0;
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      logic [15:0] exp_ctrl;
      logic [15:0] act_ctrl;
      logic [14:0] r;
      logic        iw;
      state_t      c;
      c = cur_state();
      if (reset) begin
        exp_ctrl = '0;
        chk("imm_sel", {29'd0, bus.imm_sel}, 32'd0);
        chk("instret", bus.instret, 32'd0);
        chk("state", {28'd0, bus.state}, 32'd0);
      end else begin
        r  = row(c);
        iw = (c == S_FETCH) && bus.mem_ready;
        if (iw) r[11] = 1'b1;
        if (c == S_BRANCH) r[11] = bus.branch_taken;
        exp_ctrl = {iw, r};
        chk("imm_sel", {29'd0, bus.imm_sel}, {29'd0, imm_model(bus.opcode)});
        chk("instret", bus.instret, instret_m);
        chk("state", {28'd0, bus.state}, {28'd0, c});
      end
      act_ctrl = {bus.ir_write, bus.mem_valid, bus.mem_we, bus.addr_sel, bus.pc_write,
                  bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
                  bus.wb_sel, bus.trap};
      chk("ctrl", {16'd0, act_ctrl}, {16'd0, exp_ctrl});
    end
  end

  task automatic drive(input logic r, input logic rdy, input logic tk);
    reset = r;
    bus.mem_ready = rdy;
    bus.branch_taken = tk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic run_instr(input logic [6:0] op, input int waits, input logic tk,
                           output int cyc, output logic saw_pw, output logic [2:0] dec_imm);
    int w;
    logic rdy;
    next_op = op;
    cyc = 0; w = 0; saw_pw = 1'b0; dec_imm = 3'd0;
    do begin
      rdy = 1'b1;
      if ((cur_state() == S_MEM_RD || cur_state() == S_MEM_WR) && w < waits) begin
        rdy = 1'b0;
        w++;
      end
      drive(1'b0, rdy, tk);
      #2;
      if (cur_state() != S_FETCH) saw_pw = saw_pw | bus.pc_write;
      if (cur_state() == S_DECODE) dec_imm = bus.imm_sel;
      tick();
      cyc++;
    end while (!(idx == 0 && cur_state() == S_FETCH) && cyc < 20);
  endtask

  logic [6:0] pool [11];

  initial begin
    int cyc;
    logic pw;
    logic [2:0] im;
    pool = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
             7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000};
    steps = '{S_FETCH};
    idx = 0; illegal = 1'b0; instret_m = 32'd0; run_chk = 1'b0;
    next_op = 7'b0010011;
    bus.opcode = 7'b0000000;
    drive(1'b1, 1'b1, 1'b0);
    tick();
    run_chk = 1'b1;

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      #2;
      chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      chk("rst_state", {28'd0, bus.state}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    #2;
    chk("rel_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("rel_addr_sel", {31'd0, bus.addr_sel}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      #2;
      chk("addi_reg_write", {31'd0, bus.reg_write}, (i == 2) ? 32'd1 : 32'd0);
      chk("addi_state", {28'd0, bus.state}, 32'd2 + 32'(i) + ((i == 0) ? 32'd0 : 32'd0) - ((i == 0) ? 32'd1 : 32'd0) + ((i > 0) ? 32'd0 : 32'd0));
      chk("addi_imm_sel", {29'd0, bus.imm_sel}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    #2;
    chk("addi_instret", bus.instret, 32'd1);

    run_instr(7'b0000011, 2, 1'b0, cyc, pw, im);
    chk("load_latency", 32'(cyc), 32'd7);
    chk("load_instret", bus.instret, 32'd2);
    run_instr(7'b1100011, 0, 1'b1, cyc, pw, im);
    chk("br_taken_latency", 32'(cyc), 32'd3);
    chk("br_taken_pc_write", {31'd0, pw}, 32'd1);
    chk("br_imm_sel", {29'd0, im}, 32'd2);
    run_instr(7'b1100011, 0, 1'b0, cyc, pw, im);
    chk("br_not_latency", 32'(cyc), 32'd3);
    chk("br_not_pc_write", {31'd0, pw}, 32'd0);
    chk("br_instret", bus.instret, 32'd4);
    run_instr(7'b0100011, 0, 1'b0, cyc, pw, im);
    chk("store_latency", 32'(cyc), 32'd4);
    run_instr(7'b1101111, 0, 1'b0, cyc, pw, im);
    chk("jal_latency", 32'(cyc), 32'd3);
    chk("jal_instret", bus.instret, 32'd6);

    next_op = 7'b1111111;
    drive(1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    #2;
    chk("illegal_imm_sel", {29'd0, bus.imm_sel}, 32'd7);
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #2;
      chk("trap_held", {31'd0, bus.trap}, 32'd1);
      chk("trap_state", {28'd0, bus.state}, 32'd14);
      chk("trap_instret", bus.instret, 32'd6);
      tick();
    end
`else
    drive(1'b0, 1'b0, 1'b0);
    #2;
    chk("nop_state", {28'd0, bus.state}, 32'd0);
    chk("nop_trap", {31'd0, bus.trap}, 32'd0);
    chk("nop_instret", bus.instret, 32'd6);
    tick();
`endif

    drive(1'b1, 1'b0, 1'b0);
    tick();
    run_instr(7'b0010011, 0, 1'b0, cyc, pw, im);
    chk("pre_store_instret", bus.instret, 32'd1);
    next_op = 7'b0100011;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      #2;
      chk("store_wait_we", {31'd0, bus.mem_we}, 32'd1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0);
    #2;
    chk("rst_drop_valid", {31'd0, bus.mem_valid}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_wr_state", {28'd0, bus.state}, 32'd0);
    chk("rst_wr_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_wr_instret", bus.instret, 32'd0);
    tick();

    for (int i = 0; i < 4000; i++) begin
      next_op = pool[$urandom_range(0, 10)];
      drive(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)));
      tick();
    end

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
